disp_scan_mux: RTL and testbench
================================

DISP_SCAN_MUX -- requirements
Module: disp_scan_mux

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter PRESCALE, default 1000: clk cycles per digit slot; legal values >= 2.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 load  input  1  single-cycle request to capture value.
REQ-006 value  input  16  four hex digits; bits [3:0] are digit 0, the least significant.
REQ-007 load_ack  output  1  one-cycle pulse when a captured value is committed to the display.
REQ-008 hex_digit  output  4  nibble of the digit currently scanned; feeds the 7-segment decoder.
REQ-009 digit_en_n  output  4  active-low one-hot digit select; bit i enables digit i.
REQ-010 frame_tick  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.
REQ-011 blank  output  1  high when the current digit is suppressed; 0 when LEADING_ZERO_BLANK_EN is undefined.

Function
REQ-012 The prescaler SHALL count 0..PRESCALE-1, wrap to 0, and assert an internal tick in the cycle where count == PRESCALE-1.
REQ-013 On each tick, the digit index idx SHALL advance by 1 modulo 4 in the sequence 0,1,2,3,0.
REQ-014 hex_digit SHALL equal disp_reg[4*idx+3:4*idx], and digit_en_n SHALL equal ~(1<<idx); both change in the cycle after the tick.
REQ-015 frame_tick SHALL pulse high for exactly the first cycle in which idx == 0 after a 3->0 wrap.
REQ-016 load SHALL write value into pending_reg and set pending_valid; a later load before commit SHALL overwrite pending_reg (latest wins).
REQ-017 Commit SHALL occur only on the tick that wraps idx 3->0, so the display never tears mid-frame.
REQ-018 If pending_valid is set at commit: disp_reg <= pending_reg, pending_valid clears, and load_ack pulses in the next cycle together with frame_tick.
REQ-019 load and commit in the same cycle: the old pending_reg SHALL be committed, the new value SHALL become pending, and pending_valid SHALL stay 1.
REQ-020 A wrap with pending_valid == 0 SHALL leave disp_reg unchanged and keep load_ack low.
REQ-021 load SHALL never be ignored; no backpressure output exists.

Reset
REQ-022 On rst_n low, immediately and independent of clk, the following SHALL be set: prescaler 0, idx 0, disp_reg 0, pending_reg 0, pending_valid 0, hex_digit 0, digit_en_n 4'b1110, load_ack 0, frame_tick 0, blank 0.
REQ-023 Reset deassertion SHALL restart scanning from digit 0 with a full PRESCALE slot.
REQ-024 A reset in mid-frame SHALL discard any pending value without a load_ack pulse.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN defined: a digit i > 0 SHALL be blanked when it and all higher digits of disp_reg are 0.
REQ-026 For a blanked digit, digit_en_n SHALL be all ones and blank SHALL be 1.
REQ-027 Digit 0 SHALL never be blanked.
REQ-028 Macro undefined: all four digits SHALL always be enabled, and blank SHALL be tied to 0.

Structure
REQ-029 Shared package disp_pkg SHALL hold NUM_DIGITS = 4, DIGIT_W = 4, and DIGIT_EN_RESET = 4'b1110.
REQ-030 The prescaler SHALL be sub-module scan_tick_gen (parameter PRESCALE; ports clk, rst_n, tick).
REQ-031 The block SHALL contain no segment decoding; hex_digit drives the existing decoder externally.

Verification
REQ-032 Hold rst_n low -> all outputs at their REQ-022 values; digit_en_n = 1110.
REQ-033 PRESCALE=4, load 0x1234, wait for commit -> hex_digit sequence 4,3,2,1 with digit_en_n 1110,1101,1011,0111, each for 4 cycles; frame_tick once per 16 cycles.
REQ-034 load 0xABCD while idx=1 -> display unchanged until the wrap; load_ack and frame_tick then pulse together; next frame shows D,C,B,A.
REQ-035 load 0x1111 pending, then load 0x2222 in the exact commit cycle -> 0x1111 displayed with load_ack; the next wrap commits 0x2222 with a second load_ack.
REQ-036 LEADING_ZERO_BLANK_EN defined, commit 0x0050 -> digits 3 and 2 blank (digit_en_n 1111, blank=1); digits 1 and 0 show 5 and 0. Commit 0x0000 -> only digit 0 shown.
REQ-037 Assert rst_n low at idx=2 with a value pending -> immediate reset values; after release, the scan restarts at digit 0, disp_reg = 0, and load_ack is never seen.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and digit helpers for the multiplexed hex display scanner.
package disp_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W    = 4;
   localparam int IDX_W      = 2;
   localparam int VALUE_W    = NUM_DIGITS * DIGIT_W;

   localparam logic [NUM_DIGITS-1:0] DIGIT_EN_RESET = 4'b1110;
   localparam logic [IDX_W-1:0]      LAST_IDX       = IDX_W'(NUM_DIGITS - 1);

   // Active-low one-hot select: the reset pattern rotated left by idx.
   function automatic logic [NUM_DIGITS-1:0] digit_sel_n(input logic [IDX_W-1:0] idx);
      logic [2*NUM_DIGITS-1:0] dbl;
      dbl = {DIGIT_EN_RESET, DIGIT_EN_RESET} << idx;
      return dbl[2*NUM_DIGITS-1 -: NUM_DIGITS];
   endfunction

   function automatic logic [DIGIT_W-1:0] digit_of(input logic [VALUE_W-1:0] v,
                                                   input logic [IDX_W-1:0]   idx);
      return v[int'(idx)*DIGIT_W +: DIGIT_W];
   endfunction

   // True when digit idx (> 0) and every digit above it are zero.
   function automatic logic lead_zero(input logic [VALUE_W-1:0] v,
                                      input logic [IDX_W-1:0]   idx);
      logic z;
      z = (idx != '0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i >= int'(idx) && v[i*DIGIT_W +: DIGIT_W] != '0) z = 1'b0;
      end
      return z;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-slot prescaler: counts 0..PRESCALE-1 and flags the last count of each slot.
module scan_tick_gen #(
   parameter int unsigned PRESCALE = 1000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      tick  = (cnt_q == LAST);
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/disp_scan_mux.sv
// Four-digit hex display scanner; new values are committed only at the frame wrap.
// Define LEADING_ZERO_BLANK_EN to suppress leading zero digits above digit 0.
module disp_scan_mux
   import disp_pkg::*;
#(
   parameter int unsigned PRESCALE = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [VALUE_W-1:0]    value,
   output logic                  load_ack,
   output logic [DIGIT_W-1:0]    hex_digit,
   output logic [NUM_DIGITS-1:0] digit_en_n,
   output logic                  frame_tick,
   output logic                  blank
);

   logic                 tick;
   logic                 wrap;
   logic [IDX_W-1:0]     idx_q,        idx_d;
   logic [VALUE_W-1:0]   disp_q,       disp_d;
   logic [VALUE_W-1:0]   pend_q,       pend_d;
   logic                 pend_vld_q,   pend_vld_d;
   logic                 load_ack_q,   load_ack_d;
   logic                 frame_tick_q, frame_tick_d;
   logic                 blank_c;

   scan_tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Commit uses the pending value held before this cycle, so a simultaneous
   // load simply becomes the next pending value.
   always_comb begin
      wrap         = tick && (idx_q == LAST_IDX);
      idx_d        = tick ? idx_q + IDX_W'(1) : idx_q;
      disp_d       = disp_q;
      pend_d       = pend_q;
      pend_vld_d   = pend_vld_q;
      load_ack_d   = 1'b0;
      frame_tick_d = wrap;
      if (wrap && pend_vld_q) begin
         disp_d     = pend_q;
         pend_vld_d = 1'b0;
         load_ack_d = 1'b1;
      end
      if (load) begin
         pend_d     = value;
         pend_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q        <= '0;
         disp_q       <= '0;
         pend_q       <= '0;
         pend_vld_q   <= 1'b0;
         load_ack_q   <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         disp_q       <= disp_d;
         pend_q       <= pend_d;
         pend_vld_q   <= pend_vld_d;
         load_ack_q   <= load_ack_d;
         frame_tick_q <= frame_tick_d;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      blank_c = lead_zero(disp_q, idx_q);
   end
`else
   always_comb begin
      blank_c = 1'b0;
   end
`endif

   always_comb begin
      hex_digit  = digit_of(disp_q, idx_q);
      digit_en_n = blank_c ? '1 : digit_sel_n(idx_q);
      blank      = blank_c;
      load_ack   = load_ack_q;
      frame_tick = frame_tick_q;
   end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Bench for disp_scan_mux: constant vector table, corner sequences, random loads vs. a cycle-count model.
module tb_disp_scan_mux;

   localparam int P     = 4;
   localparam int FRAME = 4 * P;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        load  = 1'b0;
   logic [15:0] value = 16'h0;
   logic        load_ack;
   logic [3:0]  hex_digit;
   logic [3:0]  digit_en_n;
   logic        frame_tick;
   logic        blank;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b1;

   disp_scan_mux #(.PRESCALE(P)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .value      (value),
      .load_ack   (load_ack),
      .hex_digit  (hex_digit),
      .digit_en_n (digit_en_n),
      .frame_tick (frame_tick),
      .blank      (blank)
   );

   always #5 clk = ~clk;

   // Model: m_n counts rising edges since reset; slot index and frame boundaries follow arithmetically.
   int          m_n    = 0;
   logic [15:0] m_disp = 16'h0;
   logic [15:0] m_pend = 16'h0;
   bit          m_pv   = 1'b0;
   bit          m_ack  = 1'b0;
   bit          m_ft   = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n = 0; m_disp = 16'h0; m_pend = 16'h0; m_pv = 1'b0; m_ack = 1'b0; m_ft = 1'b0;
      end else begin
         m_n   = m_n + 1;
         m_ft  = (m_n % FRAME) == 0;
         m_ack = m_ft && m_pv;
         if (m_ack) begin
            m_disp = m_pend;
            m_pv   = 1'b0;
         end
         if (load) begin
            m_pend = value;
            m_pv   = 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      int          idx;
      logic [15:0] sh;
      bit          bl;
      logic [3:0]  en;
      idx = (m_n / P) % 4;
      sh  = m_disp >> (4 * idx);
      bl  = LZB && (idx > 0) && (sh == 16'h0);
      en  = bl ? 4'hF : (4'b1111 ^ (4'b0001 << idx));
      chk("model_hex_digit",  16'(hex_digit),  sh & 16'h000F);
      chk("model_digit_en_n", 16'(digit_en_n), 16'(en));
      chk("model_blank",      16'(blank),      16'(bl));
      chk("model_frame_tick", 16'(frame_tick), 16'(m_ft));
      chk("model_load_ack",   16'(load_ack),   16'(m_ack));
   endtask

   always @(negedge clk) begin
      if (mon_en) check_model();
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_hex_digit"},  16'(hex_digit),  16'h0);
      chk({tag, "_digit_en_n"}, 16'(digit_en_n), 16'hE);
      chk({tag, "_blank"},      16'(blank),      16'h0);
      chk({tag, "_frame_tick"}, 16'(frame_tick), 16'h0);
      chk({tag, "_load_ack"},   16'(load_ack),   16'h0);
   endtask

   // Wait (at negedges) until m_n % FRAME == phase; bounded.
   task automatic wait_phase(input int phase);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 2 * FRAME && !hit; i++) begin
         if ((m_n % FRAME) == phase) hit = 1'b1;
         else @(negedge clk);
      end
      if (!hit) chk("wait_phase_timeout", 16'h0, 16'h1);
   endtask

   task automatic wait_ack(output bit seen, output int cyc);
      seen = 1'b0;
      cyc  = 0;
      for (int i = 0; i < 3 * FRAME && !seen; i++) begin
         @(negedge clk);
         cyc++;
         if (load_ack) seen = 1'b1;
      end
   endtask

   task automatic pulse_load(input logic [15:0] v);
      load  = 1'b1;
      value = v;
      @(negedge clk);
      load  = 1'b0;
   endtask

   typedef struct {
      logic [15:0] value;
      logic [15:0] hex_seq;   // nibble k = digit shown in slot k
      logic [15:0] en_seq;    // nibble k = digit_en_n in slot k
      logic [3:0]  blank_seq; // bit k = blank in slot k
   } vec_t;

   vec_t vecs[5];

   initial begin
      bit seen;
      int cyc;
      int ft_cnt;
      int ack_cnt;

      vecs[0] = '{16'h1234, 16'h1234, 16'h7BDE, 4'b0000};
      vecs[1] = '{16'hABCD, 16'hABCD, 16'h7BDE, 4'b0000};
      vecs[2] = '{16'hF00F, 16'hF00F, 16'h7BDE, 4'b0000};
      if (LZB) begin
         vecs[3] = '{16'h0050, 16'h0050, 16'hFFDE, 4'b1100};
         vecs[4] = '{16'h0000, 16'h0000, 16'hFFFE, 4'b1110};
      end else begin
         vecs[3] = '{16'h0050, 16'h0050, 16'h7BDE, 4'b0000};
         vecs[4] = '{16'h0000, 16'h0000, 16'h7BDE, 4'b0000};
      end

      #1;
      check_reset_outputs("reset_hold");
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_hold_late");
      #1 rst_n = 1'b1;

      // Table vectors: load during slot 1, then inspect every slot of the committed frame.
      foreach (vecs[v]) begin
         @(negedge clk);
         wait_phase(P);
         pulse_load(vecs[v].value);
         wait_ack(seen, cyc);
         chk("vec_ack_seen", 16'(seen), 16'h1);
         chk("vec_ack_with_frame_tick", 16'(frame_tick), 16'h1);
         for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (P) @(negedge clk);
            chk("vec_hex_digit",  16'(hex_digit),  16'(vecs[v].hex_seq[4*k +: 4]));
            chk("vec_digit_en_n", 16'(digit_en_n), 16'(vecs[v].en_seq[4*k +: 4]));
            chk("vec_blank",      16'(blank),      16'(vecs[v].blank_seq[k]));
         end
      end

      // Pending 0x1111, then a new load exactly in the commit cycle.
      @(negedge clk);
      wait_phase(P);
      pulse_load(16'h1111);
      wait_phase(FRAME - 1);
      pulse_load(16'h2222);
      chk("same_cycle_first_ack", 16'(load_ack),  16'h1);
      chk("same_cycle_first_hex", 16'(hex_digit), 16'h1);
      wait_ack(seen, cyc);
      chk("same_cycle_second_ack", 16'(seen), 16'h1);
      chk("same_cycle_second_gap", 16'(cyc), 16'(FRAME));
      chk("same_cycle_second_hex", 16'(hex_digit), 16'h2);

      ft_cnt = 0;
      repeat (4 * FRAME) begin
         @(negedge clk);
         if (frame_tick) ft_cnt++;
      end
      chk("frame_tick_count", 16'(ft_cnt), 16'h4);

      // Mid-frame reset with a value pending.
      wait_phase(2 * P);
      pulse_load(16'h7777);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      repeat (2) @(negedge clk);
      check_reset_outputs("async_reset_hold");
      #1 rst_n = 1'b1;
      ack_cnt = 0;
      repeat (P - 1) @(negedge clk);
      chk("restart_slot0_en", 16'(digit_en_n), 16'hE);
      @(negedge clk);
      chk("restart_slot1_en", 16'(digit_en_n), 16'hD);
      chk("restart_disp_zero", 16'(hex_digit), 16'h0);
      repeat (2 * FRAME) begin
         @(negedge clk);
         if (load_ack) ack_cnt++;
      end
      chk("reset_discards_pending", 16'(ack_cnt), 16'h0);

      // Random loads, all checked by the per-cycle model monitor.
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         load  = ($urandom_range(0, 5) == 0);
         value = 16'($urandom);
      end
      @(negedge clk);
      load = 1'b0;
      repeat (2 * FRAME) @(negedge clk);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
